// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;
    localparam int   CNT_W    = 16;

    // Modulo-ch increment of a channel index.
    function automatic int next_idx(input int idx, input int ch);
        return (idx >= ch - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter. The search starts at the channel after ptr and wraps.
// This block is combinational only.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int CH = 4,
    localparam int SW = $clog2(CH)
) (
    input  logic [CH-1:0] req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt,
    output logic          gnt_vld
);

    always_comb begin
        int              idx;
        logic [SW-1:0]   idx_s;
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = int'(ptr);
        idx_s   = '0;
        // The lowest offset from ptr wins. Later hits are ignored once one is found.
        for (int k = 0; k < CH; k++) begin
            idx   = next_idx(idx, CH);
            idx_s = SW'(idx);
            if (!gnt_vld && req[idx_s]) begin
                gnt     = idx_s;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// Registered CH-to-1 valid/ready stream mux with explicit-select and round-robin modes.
// Optional transfer counter port xfer_cnt when STREAM_MUX_CNT_EN is defined.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter  int CH = 4,
    parameter  int W  = 8,
    localparam int SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [CH*W-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready
`ifdef STREAM_MUX_CNT_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt
`endif
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic [SW-1:0] rr_gnt, gnt;
    logic          rr_gnt_vld, gnt_vld;
    logic          can_load, load;

    rr_arbiter #(.CH(CH)) u_rr (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .gnt_vld (rr_gnt_vld)
    );

    always_comb begin
        gnt     = sel;
        gnt_vld = 1'b0;
        if (mode == MODE_RR) begin
            gnt     = rr_gnt;
            gnt_vld = rr_gnt_vld;
        end else if (int'(sel) < CH) begin
            gnt_vld = in_valid[sel];
        end
    end

    assign can_load = ~out_valid_q | out_ready;

    // Gating with rst_n keeps producers from handing over words while the register is held in reset.
    for (genvar gi = 0; gi < CH; gi++) begin : g_ready
        assign in_ready[gi] = rst_n & en & can_load & gnt_vld & (gnt == SW'(gi));
    end

    assign load = |(in_valid & in_ready);

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_data_d  = in_data[int'(gnt)*W +: W];
            out_ch_d    = gnt;
            out_valid_d = 1'b1;
            if (mode == MODE_RR) ptr_d = gnt;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SW'(CH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

`ifdef STREAM_MUX_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_q && out_ready && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux.sv
// Directed self-checking bench for stream_mux (CH=4, W=8).
module tb_stream_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
`ifdef STREAM_MUX_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] dat [4];
    logic [1:0] exp_ch;

    always #5 clk = ~clk;

    stream_mux #(.CH(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef STREAM_MUX_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'hA5; dat[3] = 8'h3C;
        in_data   = {dat[3], dat[2], dat[1], dat[0]};
        rst_n     = 1'b0;
        en        = 1'b1;
        mode      = 1'b1;
        sel       = 2'd0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;

        // Reset held with every channel valid
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_ch",    32'(out_ch),    32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);

        // Release in RR: channel 0 first, then 1,2,3,0,1,2,3
        rst_n = 1'b1;
        #1;
        check("rr_first_ready", 32'(in_ready), 32'b0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_ch = 2'(k);
            check($sformatf("rr_all_valid_%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("rr_all_ch_%0d", k),    32'(out_ch),    32'(exp_ch));
            check($sformatf("rr_all_data_%0d", k),  32'(out_data),  32'(dat[exp_ch]));
        end

        // RR with only channels 1 and 3 valid
        in_valid = 4'b1010;
        #1;
        check("rr_sparse_ready", 32'(in_ready), 32'b0010);
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_ch = (k % 2 == 0) ? 2'd1 : 2'd3;
            check($sformatf("rr_sparse_ch_%0d", k),   32'(out_ch),   32'(exp_ch));
            check($sformatf("rr_sparse_data_%0d", k), 32'(out_data), 32'(dat[exp_ch]));
        end

        // Explicit select of channel 2, sustained
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111;
        #1;
        check("sel_ready", 32'(in_ready), 32'b0100);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("sel_valid_%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("sel_ch_%0d", k),    32'(out_ch),    32'd2);
            check($sformatf("sel_data_%0d", k),  32'(out_data),  32'hA5);
        end

        // Backpressure: hold the word while sel moves to channel 1
        out_ready = 1'b0; sel = 2'd1;
        #1;
        check("bp_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_ch_%0d", k),    32'(out_ch),    32'd2);
            check($sformatf("bp_data_%0d", k),  32'(out_data),  32'hA5);
            check($sformatf("bp_ready_%0d", k), 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'b0010);
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd1);
        check("bp_release_ch",    32'(out_ch),    32'd1);
        check("bp_release_data",  32'(out_data),  32'h21);

        // en low: the held word drains, nothing new is accepted
        en = 1'b0;
        #1;
        check("en0_ready", 32'(in_ready), 32'd0);
        tick();
        check("en0_valid", 32'(out_valid), 32'd0);
        check("en0_data_kept", 32'(out_data), 32'h21);
        tick();
        check("en0_valid_stays", 32'(out_valid), 32'd0);

        // Back to RR: ptr still points at 3 from the last RR grant, so ch0 is next
        mode = 1'b1; en = 1'b1;
        #1;
        check("resume_ready", 32'(in_ready), 32'b0001);
        tick();
        check("resume_ch",   32'(out_ch),   32'd0);
        check("resume_data", 32'(out_data), 32'h10);

        // Async reset mid-stream drops the held word at once
        out_ready = 1'b0;
        tick();
        check("pre_arst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data",  32'(out_data),  32'd0);
        check("arst_ch",    32'(out_ch),    32'd0);

`ifdef STREAM_MUX_CNT_EN
        tick();
        check("cnt_reset", 32'(xfer_cnt), 32'd0);
        out_ready = 1'b1;
        rst_n     = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check("cnt_five", 32'(xfer_cnt), 32'd5);
        for (int k = 0; k < 65540; k++) tick();
        check("cnt_saturate", 32'(xfer_cnt), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_mux.md
Name: stream_mux

Overview:
- Parametrised, registered N-to-1 stream multiplexer; next generation of the team's 4:1 enable-gated bit mux.
- Generalised to CH channels of W-bit data with valid/ready handshakes.
- Two selection modes: explicit select, or fair round-robin across valid channels.
- Sits between multiple producer blocks and a single shared consumer (e.g. UART TX, display driver). One output register stage.

Parameters:
- CH, 4, number of input channels (>=2).
- W, 8, data width per channel.
- SW, $clog2(CH), select/channel-index width (localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  acceptance enable. Low blocks new transfers; the output still drains.
- mode  in  1  0 = explicit select (MODE_SEL), 1 = round-robin (MODE_RR).
- sel  in  SW  channel index used in MODE_SEL.
- in_data  in  CH*W  channel i occupies bits [i*W +: W].
- in_valid  in  CH  per-channel valid.
- in_ready  out  CH  per-channel ready, at most one bit high.
- out_data  out  W  registered output data.
- out_ch  out  SW  index of the channel that supplied out_data.
- out_valid  out  1  output valid.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset (async assert, sync deassert handled upstream): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=CH-1, so channel 0 has first priority.
- Grant, combinational:
  - MODE_SEL: gnt=sel, gnt_vld=in_valid[sel]. If sel>=CH, gnt_vld=0.
  - MODE_RR: gnt = first i with in_valid[i], searching ptr+1, ptr+2, ... with wrap modulo CH. gnt_vld = |in_valid.
- can_load = ~out_valid | out_ready. This is a pass-through bubble-free register: full throughput, one word per cycle.
- in_ready[i] = en & can_load & gnt_vld & (gnt==i). in_ready may depend on in_valid; producers must not wait on ready before asserting valid.
- Transfer on channel i: in_valid[i] & in_ready[i]. The register then loads out_data=in_data[i], out_ch=i, out_valid=1 at the next edge. Latency: 1 cycle from input transfer to out_valid.
- Output side:
  - out_valid & out_ready with no new load → out_valid=0 next cycle.
  - Output held stable while out_valid & ~out_ready.
  - out_data is not cleared when the output drains.
- ptr updates to gnt only on a transfer while mode=MODE_RR. It is unchanged in MODE_SEL and unchanged by en=0.
- Mode or sel changes take effect in the same cycle's combinational grant. No transfer is lost or duplicated, because the register has already captured the data.
- en falling with out_valid=1: the word still drains normally.
- Reset asserted mid-stream: the held output word is discarded and out_valid drops immediately (async).
- Simultaneous drain and load in the same cycle: the load wins, out_valid stays 1, and the new data appears.

Optional Feature:
- Macro: STREAM_MUX_CNT_EN.
- Defined: adds output port xfer_cnt [15:0].
  - Counts output-side transfers (out_valid & out_ready).
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst_n.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package stream_mux_pkg:
  - MODE_SEL=1'b0, MODE_RR=1'b1.
  - CNT_W=16.
  - Function next_idx(idx, CH) for modulo increment.
- Sub-module rr_arbiter (params CH):
  - Inputs: req[CH], ptr.
  - Outputs: gnt index, gnt_vld.
  - Purely combinational; instantiated once, used only in MODE_RR.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0. Release with mode=RR, en=1 → first transfer from ch0, out_ch=0 one cycle later.
- MODE_SEL, sel=2, in_valid=4'b1111, in_data ch2=8'hA5, out_ready=1 → only in_ready[2]=1; out_data=8'hA5, out_ch=2 next cycle, one word per cycle sustained.
- MODE_RR, all 4 valid, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3. With in_valid=4'b1010 → sequence 1,3,1,3.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → out_data/out_ch stable, in_ready all 0. out_ready=1 → one drain plus new load in the same cycle, no gap.
- en=0 with out_valid=1, out_ready=1 → word drains, out_valid=0 next cycle, no in_ready asserted. ptr is unchanged: re-enabling in RR resumes after the last granted channel.
- STREAM_MUX_CNT_EN defined: 5 output transfers → xfer_cnt=5. Preload near saturation via a long run → holds 16'hFFFF.
